// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - condition-code register with nested interrupt freeze stack
module ccr_unit #(
   parameter int STACK_DEPTH = 2,
   parameter int DEPTH_W     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         flagsIn,
   input  logic               ccrWrite,
   input  logic               stall,
   input  logic               interruptTaken,
   input  logic               rtiCommit,
   output logic [3:0]         ccrOut,
   output logic [3:0]         freezedCCR,
   output logic [DEPTH_W-1:0] depth,
   output logic               overflowErr,
   output logic               underflowErr
);

   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

   logic [3:0]         ccr;
   logic [3:0]         stack [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q;
   logic               ovf_q;
   logic               unf_q;

   logic [3:0]         snapshot;
   logic [DEPTH_W-1:0] top_idx;
   logic               empty;
   logic               full;
   logic               do_push;
   logic               do_pop;
   logic               do_replace;
   logic               push_over;
   logic               pop_under;

   // Snapshot is the next-CCR so a flag-producing op retiring with the interrupt is kept.
   always_comb begin
      snapshot   = ccrWrite ? flagsIn : ccr;
      empty      = (depth_q == '0);
      full       = (depth_q == FULL_DEPTH);
      top_idx    = depth_q - DEPTH_W'(1);
      do_replace = interruptTaken & rtiCommit & ~empty;
      do_push    = interruptTaken & ~do_replace & ~full;
      push_over  = interruptTaken & ~rtiCommit & full;
      do_pop     = rtiCommit & ~interruptTaken & ~empty;
      pop_under  = rtiCommit & ~interruptTaken & empty;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ccr     <= 4'b0000;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack[i] <= 4'b0000;
         end
      end else if (!stall) begin
         if (ccrWrite) begin
            ccr <= flagsIn;
         end
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (do_push && DEPTH_W'(i) == depth_q) begin
               stack[i] <= snapshot;
            end else if (do_replace && DEPTH_W'(i) == top_idx) begin
               stack[i] <= snapshot;
            end else if (do_pop && DEPTH_W'(i) == top_idx) begin
               stack[i] <= 4'b0000;
            end
         end
         if (do_push) begin
            depth_q <= depth_q + DEPTH_W'(1);
         end else if (do_pop) begin
            depth_q <= top_idx;
         end
         if (push_over) begin
            ovf_q <= 1'b1;
         end
         if (pop_under) begin
            unf_q <= 1'b1;
         end
      end
   end

   always_comb begin
      freezedCCR = 4'b0000;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (!empty && DEPTH_W'(i) == top_idx) begin
            freezedCCR = stack[i];
         end
      end
   end

   assign ccrOut       = ccr;
   assign depth        = depth_q;
   assign overflowErr  = ovf_q;
   assign underflowErr = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// tb/tb_ccr_unit.sv - self-checking bench for ccr_unit against a queue-based flag model
module tb_ccr_unit;

   localparam int SD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] flagsIn = 4'b0;
   logic       ccrWrite = 1'b0;
   logic       stall = 1'b0;
   logic       interruptTaken = 1'b0;
   logic       rtiCommit = 1'b0;
   logic [3:0] ccrOut;
   logic [3:0] freezedCCR;
   logic [1:0] depth;
   logic       overflowErr;
   logic       underflowErr;

   int total = 0;
   int bad = 0;

   logic [3:0] m_ccr;
   logic [3:0] q[$];
   logic       m_ovf;
   logic       m_unf;

   ccr_unit #(.STACK_DEPTH(SD), .DEPTH_W(2)) dut (
      .clk(clk), .rst(rst), .flagsIn(flagsIn), .ccrWrite(ccrWrite), .stall(stall),
      .interruptTaken(interruptTaken), .rtiCommit(rtiCommit), .ccrOut(ccrOut),
      .freezedCCR(freezedCCR), .depth(depth), .overflowErr(overflowErr),
      .underflowErr(underflowErr)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] f, input logic w, input logic s,
                        input logic it, input logic rti);
      flagsIn = f; ccrWrite = w; stall = s; interruptTaken = it; rtiCommit = rti;
   endtask

   // Advance the model by one clock using the architectural rules, then clock the DUT.
   task automatic cycle();
      logic [3:0] snap;
      if (!stall) begin
         snap = ccrWrite ? flagsIn : m_ccr;
         if (interruptTaken && rtiCommit && q.size() > 0) q[q.size()-1] = snap;
         else if (interruptTaken) begin
            if (q.size() < SD) q.push_back(snap);
            else m_ovf = 1'b1;
         end else if (rtiCommit) begin
            if (q.size() > 0) void'(q.pop_back());
            else m_unf = 1'b1;
         end
         if (ccrWrite) m_ccr = flagsIn;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      m_ccr = 4'b0; q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (ccrOut !== 4'b0) begin bad++; $display("FAIL reset_ccr got=%b exp=0000", ccrOut); end
      total++; if (depth !== 2'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      total++; if (freezedCCR !== 4'b0) begin bad++; $display("FAIL reset_frz got=%b exp=0000", freezedCCR); end
      total++; if ({overflowErr, underflowErr} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {overflowErr, underflowErr}); end
      drive(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
      total++; if (ccrOut !== 4'b1010) begin bad++; $display("FAIL write_ccr got=%b exp=1010", ccrOut); end
      total++; if (depth !== 2'd0 || freezedCCR !== 4'b0) begin bad++; $display("FAIL write_stack got=%0d/%b exp=0/0000", depth, freezedCCR); end
   endtask

   task automatic test_interrupt_rti();
      drive(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
      drive(4'b0101, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      total++; if (ccrOut !== 4'b0101) begin bad++; $display("FAIL irq_ccr got=%b exp=0101", ccrOut); end
      total++; if (depth !== 2'd1) begin bad++; $display("FAIL irq_depth got=%0d exp=1", depth); end
      total++; if (freezedCCR !== 4'b0101) begin bad++; $display("FAIL irq_frz got=%b exp=0101", freezedCCR); end
      drive(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
      total++; if (ccrOut !== 4'b0101) begin bad++; $display("FAIL rti_ccr got=%b exp=0101", ccrOut); end
      total++; if (depth !== 2'd0 || freezedCCR !== 4'b0) begin bad++; $display("FAIL rti_stack got=%0d/%b exp=0/0000", depth, freezedCCR); end
   endtask

   task automatic test_nested_overflow();
      drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      drive(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      total++; if (depth !== 2'd2 || freezedCCR !== 4'b0010) begin bad++; $display("FAIL nest2 got=%0d/%b exp=2/0010", depth, freezedCCR); end
      total++; if (overflowErr !== 1'b0) begin bad++; $display("FAIL nest2_ovf got=%b exp=0", overflowErr); end
      drive(4'b0100, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      total++; if (overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflowErr); end
      total++; if (depth !== 2'd2 || freezedCCR !== 4'b0010) begin bad++; $display("FAIL ovf_stack got=%0d/%b exp=2/0010", depth, freezedCCR); end
      total++; if (ccrOut !== 4'b0100) begin bad++; $display("FAIL ovf_ccr got=%b exp=0100", ccrOut); end
      drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
      total++; if (depth !== 2'd1 || freezedCCR !== 4'b0001) begin bad++; $display("FAIL pop1 got=%0d/%b exp=1/0001", depth, freezedCCR); end
      cycle();
      total++; if (depth !== 2'd0 || freezedCCR !== 4'b0) begin bad++; $display("FAIL pop2 got=%0d/%b exp=0/0000", depth, freezedCCR); end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
      total++; if (underflowErr !== 1'b1 || depth !== 2'd0) begin bad++; $display("FAIL unf got=%b/%0d exp=1/0", underflowErr, depth); end
      drive(4'b0110, 1'b1, 1'b0, 1'b1, 1'b0); cycle(); cycle();
      total++; if (underflowErr !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", underflowErr); end
      total++; if (depth !== 2'd2 || freezedCCR !== 4'b0110) begin bad++; $display("FAIL unf_push got=%0d/%b exp=2/0110", depth, freezedCCR); end
      do_reset();
      total++; if (underflowErr !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", underflowErr); end
   endtask

   task automatic test_stall();
      drive(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
      drive(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0); cycle(); cycle();
      total++; if (ccrOut !== 4'b0011) begin bad++; $display("FAIL stall_ccr got=%b exp=0011", ccrOut); end
      total++; if (depth !== 2'd0 || freezedCCR !== 4'b0) begin bad++; $display("FAIL stall_stack got=%0d/%b exp=0/0000", depth, freezedCCR); end
      stall = 1'b0; cycle();
      total++; if (ccrOut !== 4'b1111) begin bad++; $display("FAIL unstall_ccr got=%b exp=1111", ccrOut); end
      total++; if (depth !== 2'd1 || freezedCCR !== 4'b1111) begin bad++; $display("FAIL unstall_stack got=%0d/%b exp=1/1111", depth, freezedCCR); end
   endtask

   task automatic test_async_reset_and_replace();
      drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      m_ccr = 4'b0; q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      total++; if (ccrOut !== 4'b0 || depth !== 2'd0 || freezedCCR !== 4'b0) begin
         bad++; $display("FAIL async_rst got=%b/%0d/%b exp=0000/0/0000", ccrOut, depth, freezedCCR);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      drive(4'b1000, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
      total++; if (depth !== 2'd1 || freezedCCR !== 4'b1000) begin bad++; $display("FAIL replace got=%0d/%b exp=1/1000", depth, freezedCCR); end
      total++; if ({overflowErr, underflowErr} !== 2'b00) begin bad++; $display("FAIL replace_err got=%b exp=00", {overflowErr, underflowErr}); end
      do_reset();
      drive(4'b1001, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
      total++; if (depth !== 2'd1 || freezedCCR !== 4'b1001) begin bad++; $display("FAIL both_empty got=%0d/%b exp=1/1001", depth, freezedCCR); end
   endtask

   task automatic test_random();
      logic [3:0] exp_frz;
      logic [1:0] exp_d;
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 0) do_reset();
         drive(4'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         cycle();
         exp_frz = (q.size() > 0) ? q[q.size()-1] : 4'b0;
         exp_d = 2'(q.size());
         total++; if (ccrOut !== m_ccr) begin bad++; $display("FAIL rnd_ccr n=%0d got=%b exp=%b", n, ccrOut, m_ccr); end
         total++; if (depth !== exp_d) begin bad++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, depth, exp_d); end
         total++; if (freezedCCR !== exp_frz) begin bad++; $display("FAIL rnd_frz n=%0d got=%b exp=%b", n, freezedCCR, exp_frz); end
         total++; if (overflowErr !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflowErr, m_ovf); end
         total++; if (underflowErr !== m_unf) begin bad++; $display("FAIL rnd_unf n=%0d got=%b exp=%b", n, underflowErr, m_unf); end
      end
   endtask

   initial begin
      test_reset();
      test_interrupt_rti();
      test_nested_overflow();
      test_underflow();
      test_stall();
      test_async_reset_and_replace();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
